// File: rtl/int_pkg.sv
// Shared definitions for the interrupt unit and the controller that consumes its outputs.
package int_pkg;

  localparam int unsigned N_IRQ_DEF   = 4;
  localparam int unsigned CAUSE_W_DEF = 2;
  localparam int unsigned GIE_BIT     = N_IRQ_DEF;

  // Encoding of the controller's INA qualifier on an acknowledge
  localparam logic INA_MASKABLE = 1'b1;
  localparam logic INA_NMI      = 1'b0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    INT_SVC      = 2'd1,
    NMI_SVC      = 2'd2,
    NMI_OVER_INT = 2'd3
  } state_t;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for an asynchronous request line followed by a rising-edge pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise_c
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      hist <= sync;
    end
  end

  // One-cycle pulse on the first synchronized cycle of a high level
  assign rise_c = sync & ~hist;

endmodule

// File: rtl/interrupt_unit.sv
// Interrupt front end for the multicycle MIPS controller: latches requests, applies mask/GIE,
// and tracks maskable and non-maskable service including NMI preemption.
module interrupt_unit
  import int_pkg::*;
#(
  parameter int unsigned N_IRQ   = N_IRQ_DEF,
  parameter int unsigned CAUSE_W = CAUSE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_IRQ-1:0]   irq,
  input  logic               nmi_pin,
  input  logic               cfg_we,
  input  logic [N_IRQ:0]     cfg_wdata,
  input  logic               ack,
  input  logic               ack_ina,
  input  logic               reti,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [CAUSE_W-1:0] cause,
  output logic [N_IRQ:0]     cfg_rdata
);

  logic [N_IRQ-1:0]   irq_rise;
  logic               nmi_rise;
  logic [N_IRQ-1:0]   pending;
  logic [N_IRQ-1:0]   pending_nxt;
  logic [N_IRQ-1:0]   int_clr;
  logic [N_IRQ-1:0]   req;
  logic               nmi_pending;
  logic               nmi_pending_nxt;
  logic               nmi_clr;
  logic [N_IRQ:0]     cfg;
  logic [CAUSE_W-1:0] sel;
  logic [CAUSE_W-1:0] cause_nxt;
  state_t             state;
  state_t             state_ret;
  state_t             state_nxt;

  for (genvar g = 0; g < int'(N_IRQ); g++) begin : g_irq
    irq_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .raw    (irq[g]),
      .rise_c (irq_rise[g])
    );
  end

  irq_sync_edge u_nmi_sync (
    .clk    (clk),
    .rst    (rst),
    .raw    (nmi_pin),
    .rise_c (nmi_rise)
  );

  assign req       = pending & cfg[N_IRQ-1:0];
  assign INT       = |req;
  assign NMI       = nmi_pending & (state != NMI_SVC) & (state != NMI_OVER_INT);
  assign INTD      = ~cfg[N_IRQ] | (state != IDLE);
  assign cfg_rdata = cfg;

  // Lowest set index wins
  always_comb begin
    sel = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (req[i]) sel = CAUSE_W'(i);
    end
  end

  always_comb begin
    state_ret       = state;
    state_nxt       = state;
    int_clr         = '0;
    nmi_clr         = 1'b0;
    cause_nxt       = cause;

    // A return is applied before an acknowledge arriving on the same edge
    if (reti) begin
      case (state)
        INT_SVC:      state_ret = IDLE;
        NMI_SVC:      state_ret = IDLE;
        NMI_OVER_INT: state_ret = INT_SVC;
        default:      state_ret = state;
      endcase
    end
    state_nxt = state_ret;

    if (ack) begin
      case (state_ret)
        IDLE: begin
          if (ack_ina == INA_NMI && nmi_pending) begin
            nmi_clr   = 1'b1;
            state_nxt = NMI_SVC;
          end else if (ack_ina == INA_MASKABLE && INT) begin
            int_clr   = N_IRQ'(1) << sel;
            cause_nxt = sel;
            state_nxt = INT_SVC;
          end
        end
        INT_SVC: begin
          if (ack_ina == INA_NMI && nmi_pending) begin
            nmi_clr   = 1'b1;
            state_nxt = NMI_OVER_INT;
          end
        end
        default: state_nxt = state_ret;
      endcase
    end

    // New edges take priority over a same-cycle clear
    pending_nxt     = (pending & ~int_clr) | irq_rise;
    nmi_pending_nxt = (nmi_pending & ~nmi_clr) | nmi_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      nmi_pending <= 1'b0;
      cfg         <= '0;
      cause       <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      nmi_pending <= nmi_pending_nxt;
      cause       <= cause_nxt;
      if (cfg_we) cfg <= cfg_wdata;
    end
  end

endmodule

// File: tb/tb_interrupt_unit.sv
// Self-checking bench for interrupt_unit: directed scenarios plus random traffic against a
// service-stack reference model.
module tb_interrupt_unit;

  localparam int SVC_INT = 0;
  localparam int SVC_NMI = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] irq = '0;
  logic       nmi_pin = 1'b0;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_wdata = '0;
  logic       ack = 1'b0;
  logic       ack_ina = 1'b0;
  logic       reti = 1'b0;
  logic       INT;
  logic       NMI;
  logic       INTD;
  logic [1:0] cause;
  logic [4:0] cfg_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: requests seen through a three-edge delay, service modelled as a stack
  logic [4:0] m_h1, m_h2, m_h3;
  logic [3:0] m_pend;
  logic       m_nmi;
  logic [3:0] m_mask;
  logic       m_gie;
  logic [1:0] m_cause;
  int         m_stack[$];

  interrupt_unit dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .nmi_pin   (nmi_pin),
    .cfg_we    (cfg_we),
    .cfg_wdata (cfg_wdata),
    .ack       (ack),
    .ack_ina   (ack_ina),
    .reti      (reti),
    .INT       (INT),
    .NMI       (NMI),
    .INTD      (INTD),
    .cause     (cause),
    .cfg_rdata (cfg_rdata)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_h1 = '0; m_h2 = '0; m_h3 = '0;
    m_pend = '0; m_nmi = 1'b0; m_mask = '0; m_gie = 1'b0; m_cause = '0;
    m_stack.delete();
  endtask

  task automatic model_update();
    logic [4:0] rise;
    logic       int_now;
    int         idx;
    rise = m_h2 & ~m_h3;
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = {nmi_pin, irq};
    int_now = |(m_pend & m_mask);
    if (reti && m_stack.size() > 0) void'(m_stack.pop_back());
    if (ack) begin
      if (m_stack.size() == 0) begin
        if (!ack_ina && m_nmi) begin
          m_nmi = 1'b0;
          m_stack.push_back(SVC_NMI);
        end else if (ack_ina && int_now) begin
          idx = 0;
          while (!(m_pend[idx] && m_mask[idx])) idx++;
          m_pend[idx] = 1'b0;
          m_cause = 2'(idx);
          m_stack.push_back(SVC_INT);
        end
      end else if (m_stack.size() == 1 && m_stack[0] == SVC_INT && !ack_ina && m_nmi) begin
        m_nmi = 1'b0;
        m_stack.push_back(SVC_NMI);
      end
    end
    m_pend = m_pend | rise[3:0];
    if (rise[4]) m_nmi = 1'b1;
    if (cfg_we) begin
      m_mask = cfg_wdata[3:0];
      m_gie  = cfg_wdata[4];
    end
  endtask

  function automatic logic [9:0] model_outputs();
    logic e_int, e_nmi, e_intd;
    e_int  = |(m_pend & m_mask);
    e_nmi  = m_nmi && (m_stack.size() == 0 || m_stack[m_stack.size()-1] == SVC_INT);
    e_intd = !m_gie || (m_stack.size() > 0);
    return {e_int, e_nmi, e_intd, m_cause, m_gie, m_mask};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    irq = '0; nmi_pin = 1'b0; cfg_we = 1'b0; cfg_wdata = '0;
    ack = 1'b0; ack_ina = 1'b0; reti = 1'b0;
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [4:0] v);
    cfg_we = 1'b1; cfg_wdata = v;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_ack(input logic ina);
    ack = 1'b1; ack_ina = ina;
    step();
    ack = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    step();
    reti = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({INT, NMI, INTD, cause, cfg_rdata} !== {1'b0, 1'b0, 1'b1, 2'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got INT=%b NMI=%b INTD=%b cause=%0d cfg=%b, want 0 0 1 0 00000",
               INT, NMI, INTD, cause, cfg_rdata);
    end
  endtask

  task automatic test_basic();
    do_reset();
    write_cfg(5'b1_0100);
    n_tests++;
    if (INTD !== 1'b0) begin n_fail++; $display("FAIL basic_intd_enabled: got %b want 0", INTD); end
    irq[2] = 1'b1;
    step(); step();
    n_tests++;
    if (INT !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: INT got %b want 0 after 2 edges", INT); end
    step();
    n_tests++;
    if (INT !== 1'b1 || INTD !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency: INT/INTD got %b/%b want 1/0 after 3 edges", INT, INTD);
    end
    step(); step();
    irq[2] = 1'b0;
    pulse_ack(1'b1);
    n_tests++;
    if ({INT, INTD, cause} !== {1'b0, 1'b1, 2'd2}) begin
      n_fail++; $display("FAIL basic_ack: INT=%b INTD=%b cause=%0d want 0 1 2", INT, INTD, cause);
    end
    pulse_reti();
    n_tests++;
    if ({INT, INTD} !== 2'b00) begin
      n_fail++; $display("FAIL basic_reti: INT=%b INTD=%b want 0 0", INT, INTD);
    end
  endtask

  task automatic test_priority();
    do_reset();
    write_cfg(5'b1_1111);
    irq = 4'b1010;
    repeat (3) step();
    irq = '0;
    pulse_ack(1'b1);
    n_tests++;
    if ({cause, INT} !== {2'd1, 1'b1}) begin
      n_fail++; $display("FAIL priority_first: cause=%0d INT=%b want 1 1", cause, INT);
    end
    pulse_reti();
    pulse_ack(1'b1);
    n_tests++;
    if ({cause, INT, INTD} !== {2'd3, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL priority_second: cause=%0d INT=%b INTD=%b want 3 0 1", cause, INT, INTD);
    end
    pulse_reti();
  endtask

  task automatic test_nmi_preempt();
    do_reset();
    write_cfg(5'b1_1111);
    irq[2] = 1'b1;
    repeat (3) step();
    irq[2] = 1'b0;
    pulse_ack(1'b1);
    nmi_pin = 1'b1;
    step(); step();
    n_tests++;
    if (NMI !== 1'b0) begin n_fail++; $display("FAIL nmi_latency_early: NMI got %b want 0", NMI); end
    step();
    n_tests++;
    if (NMI !== 1'b1) begin n_fail++; $display("FAIL nmi_in_int_svc: NMI got %b want 1", NMI); end
    nmi_pin = 1'b0;
    pulse_ack(1'b0);
    n_tests++;
    if ({NMI, INTD} !== 2'b01) begin
      n_fail++; $display("FAIL nmi_preempt: NMI=%b INTD=%b want 0 1", NMI, INTD);
    end
    pulse_reti();
    n_tests++;
    if ({INTD, cause, NMI} !== {1'b1, 2'd2, 1'b0}) begin
      n_fail++; $display("FAIL nmi_return_to_int: INTD=%b cause=%0d NMI=%b want 1 2 0", INTD, cause, NMI);
    end
    pulse_reti();
    n_tests++;
    if (INTD !== 1'b0) begin n_fail++; $display("FAIL nmi_back_to_idle: INTD got %b want 0", INTD); end
  endtask

  task automatic test_masked();
    do_reset();
    write_cfg(5'b0_0000);
    irq[0] = 1'b1;
    repeat (3) step();
    irq[0] = 1'b0;
    step();
    n_tests++;
    if ({INT, INTD} !== 2'b01) begin
      n_fail++; $display("FAIL masked_hold: INT=%b INTD=%b want 0 1", INT, INTD);
    end
    write_cfg(5'b1_0001);
    n_tests++;
    if ({INT, INTD, cfg_rdata} !== {1'b1, 1'b0, 5'b1_0001}) begin
      n_fail++; $display("FAIL masked_enable: INT=%b INTD=%b cfg=%b want 1 0 10001", INT, INTD, cfg_rdata);
    end
    pulse_ack(1'b1);
    n_tests++;
    if ({cause, INT} !== {2'd0, 1'b0}) begin
      n_fail++; $display("FAIL masked_ack: cause=%0d INT=%b want 0 0", cause, INT);
    end
    pulse_reti();
  endtask

  task automatic test_nmi_during_nmi();
    do_reset();
    nmi_pin = 1'b1;
    repeat (3) step();
    nmi_pin = 1'b0;
    step();
    pulse_ack(1'b0);
    n_tests++;
    if ({NMI, INTD} !== 2'b01) begin
      n_fail++; $display("FAIL nmi_svc_enter: NMI=%b INTD=%b want 0 1", NMI, INTD);
    end
    nmi_pin = 1'b1;
    repeat (20) step();
    n_tests++;
    if (NMI !== 1'b0) begin n_fail++; $display("FAIL nmi_svc_masked: NMI got %b want 0", NMI); end
    nmi_pin = 1'b0;
    pulse_reti();
    n_tests++;
    if (NMI !== 1'b1) begin n_fail++; $display("FAIL nmi_after_reti: NMI got %b want 1", NMI); end
    pulse_ack(1'b0);
    pulse_reti();
    repeat (3) step();
    n_tests++;
    if (NMI !== 1'b0) begin n_fail++; $display("FAIL nmi_single_request: NMI got %b want 0", NMI); end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_cfg(5'b1_1111);
    irq = 4'b0110;
    repeat (3) step();
    irq = '0;
    pulse_ack(1'b1);
    n_tests++;
    if ({cause, INT, INTD} !== {2'd1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL async_setup: cause=%0d INT=%b INTD=%b want 1 1 1", cause, INT, INTD);
    end
    #2 rst = 1'b1;
    m_reset();
    #1;
    n_tests++;
    if ({INT, NMI, INTD, cause, cfg_rdata} !== {1'b0, 1'b0, 1'b1, 2'd0, 5'd0}) begin
      n_fail++;
      $display("FAIL async_reset: INT=%b NMI=%b INTD=%b cause=%0d cfg=%b want 0 0 1 0 00000",
               INT, NMI, INTD, cause, cfg_rdata);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) irq[b] = ~irq[b];
      if ($urandom_range(11) == 0) nmi_pin = ~nmi_pin;
      cfg_we    = ($urandom_range(15) == 0);
      cfg_wdata = 5'($urandom);
      if ($urandom_range(3) == 0) cfg_wdata[4] = 1'b1;
      ack       = ($urandom_range(3) == 0);
      ack_ina   = 1'($urandom);
      reti      = ($urandom_range(5) == 0);
      step();
      got = {INT, NMI, INTD, cause, cfg_rdata};
      exp = model_outputs();
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random cycle %0d: got {INT,NMI,INTD,cause,cfg}=%b want %b", cyc, got, exp);
      end
    end
    cfg_we = 1'b0; ack = 1'b0; reti = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_nmi_preempt();
    test_masked();
    test_nmi_during_nmi();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_unit.md
Name: interrupt_unit

Overview:
- Upstream companion of the multicycle MIPS controller. Collects external maskable interrupt lines and one non-maskable pin, and applies the mask and global enable.
- Drives the controller's INT, NMI and INTD inputs and tracks in-service state.
- Gets acknowledges from the controller's preFetch interrupt entry and return pulses from the return-from-interrupt path.
- Presents a cause index to the datapath for the EPC/cause write.

Parameters:
- N_IRQ, 4, number of maskable interrupt lines; bit 0 has the highest priority.
- CAUSE_W, 2, width of the cause index; must equal clog2(N_IRQ).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq  in  N_IRQ  raw external maskable requests, asynchronous, level high.
- nmi_pin  in  1  raw non-maskable request, asynchronous.
- cfg_we  in  1  write strobe for the config register.
- cfg_wdata  in  N_IRQ+1  bits [N_IRQ-1:0] are the mask (1 = enabled); bit N_IRQ is GIE.
- ack  in  1  one-cycle pulse: the controller took an interrupt (its isInterrupted).
- ack_ina  in  1  qualifies ack: 1 = maskable taken, 0 = NMI taken (the controller's INA).
- reti  in  1  one-cycle pulse: the return-from-interrupt instruction executed.
- INT  out  1  maskable request pending.
- NMI  out  1  non-maskable request pending.
- INTD  out  1  maskable interrupts disabled.
- cause  out  CAUSE_W  index of the interrupt currently or last in service.
- cfg_rdata  out  N_IRQ+1  current {GIE, mask}.

Behaviour:
- Reset (asynchronous, any time, including mid-service):
  - Synchronizers, edge history, pending bits, nmi_pending, mask and cause all clear to 0; GIE = 0.
  - FSM goes to IDLE.
  - Outputs: INT=0, NMI=0, INTD=1, cause=0, cfg_rdata=0.
- Input synchronization and edge detection:
  - Each irq bit and nmi_pin passes through a 2-flop synchronizer, then a rising-edge detector.
  - A raw rise that meets setup before edge E1 sets its pending bit at edge E3.
  - The affected output is visible after E3: 3-cycle latency.
  - A held-high level produces only one request.
- Pending bit update:
  - A new edge sets the bit; an ack clears only the bit being acknowledged.
  - If set and clear hit the same bit in the same cycle, set wins.
- Outputs, combinational from registers only:
  - INT = |(pending & mask).
  - NMI = nmi_pending & (state != NMI_SVC) & (state != NMI_OVER_INT).
  - INTD = ~GIE | (state != IDLE).
- FSM states: IDLE, INT_SVC, NMI_SVC, NMI_OVER_INT.
  - IDLE:
    - ack & ~ack_ina & nmi_pending -> clear nmi_pending -> NMI_SVC.
    - ack & ack_ina & INT -> clear the lowest-index set bit of (pending & mask), load that index into cause -> INT_SVC.
  - INT_SVC:
    - ack & ~ack_ina & nmi_pending -> clear nmi_pending -> NMI_OVER_INT (NMI preempts).
    - reti -> IDLE.
    - A maskable ack is ignored here because INTD=1.
  - NMI_SVC: reti -> IDLE. Any ack is ignored.
  - NMI_OVER_INT: reti -> INT_SVC. cause is preserved throughout.
- Ack edge cases:
  - An ack that does not match the qualifying condition is ignored; no state or pending change.
  - ack and reti in the same cycle: reti is processed first, then ack is evaluated against the resulting state in the same edge.
- Other rules:
  - A second NMI edge during NMI service latches into nmi_pending; NMI asserts after reti.
  - Masked pending bits stay latched. Enabling the mask later raises INT on the next cycle.
  - cfg_we updates {GIE, mask} at the edge. The new value affects INT/INTD in the following cycle.
  - cfg_we and reti in the same cycle are independent.

Decomposition:
- Shared package int_pkg:
  - FSM state encoding: IDLE=0, INT_SVC=1, NMI_SVC=2, NMI_OVER_INT=3, 2 bits.
  - GIE_BIT position.
  - INA_MASKABLE=1 and INA_NMI=0 constants, also consumed by the controller.
- One sub-module, irq_sync_edge: a 2-flop synchronizer plus rising-edge pulse with async reset, instantiated N_IRQ+1 times.
- Priority encoding stays inline.

Test Plan:
1. Reset, then cfg_wdata=5'b1_0100, then pulse irq[2] high for 5 cycles -> INT=1 exactly 3 cycles after the rise, INTD=0. Ack with ack_ina=1 -> INT=0, INTD=1, cause=2. reti -> INTD=0, INT stays 0.
2. cfg=5'b1_1111, raise irq[3] and irq[1] in the same cycle -> ack gives cause=1, and INT stays 1 with bit 3 pending. reti -> ack gives cause=3.
3. In INT_SVC with cause=2, raise nmi_pin -> NMI=1. Ack with ack_ina=0 -> NMI_OVER_INT, NMI=0, INTD=1. reti -> INT_SVC, cause=2. reti -> IDLE.
4. GIE=0, mask=0, raise irq[0] -> INT=0, INTD=1, pending retained. Write cfg=5'b1_0001 -> INT=1 on the next cycle.
5. Raise nmi_pin during NMI_SVC -> NMI stays 0. reti -> NMI=1 the next cycle. Hold nmi_pin high 20 cycles -> only one request.
6. Assert rst in INT_SVC with pending bits set -> all outputs go to reset values immediately (INTD=1, INT=0, cause=0), without waiting for a clock edge.
